// File: rtl/native_apb_pkg.sv
// Shared types and default widths for the native-to-APB bridge.
package native_apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int ADDR_W_DEF  = 16;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/native_apb_bridge.sv
// Native peripheral port to two-phase APB3 master, with wait
// states, slave-error propagation and an ACCESS stall timeout.
module native_apb_bridge
   import native_apb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              nat_sel,
   input  logic              nat_write,
   input  logic [ADDR_W-1:0] nat_addr,
   input  logic [DATA_W-1:0] nat_wdata,
   output logic [DATA_W-1:0] nat_rdata,
   output logic              nat_ready,
   output logic              nat_err,
   output logic              apbm_psel,
   output logic              apbm_penable,
   output logic              apbm_pwrite,
   output logic [ADDR_W-1:0] apbm_paddr,
   output logic [DATA_W-1:0] apbm_pwdata,
   input  logic [DATA_W-1:0] apbm_prdata,
   input  logic              apbm_pready,
   input  logic              apbm_pslverr
);

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam bit TO_EN = (TIMEOUT != 0);

   state_t           state;
   logic [CNT_W-1:0] cnt;

   // APB address/data/direction are the capture registers themselves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         nat_rdata    <= '0;
         nat_ready    <= 1'b0;
         nat_err      <= 1'b0;
         apbm_psel    <= 1'b0;
         apbm_penable <= 1'b0;
         apbm_pwrite  <= 1'b0;
         apbm_paddr   <= '0;
         apbm_pwdata  <= '0;
      end else begin
         nat_ready <= 1'b0;
         unique case (state)
            IDLE: begin
               if (nat_sel) begin
                  apbm_pwrite  <= nat_write;
                  apbm_paddr   <= nat_addr;
                  apbm_pwdata  <= nat_wdata;
                  apbm_psel    <= 1'b1;
                  apbm_penable <= 1'b0;
                  state        <= SETUP;
               end
            end
            SETUP: begin
               apbm_penable <= 1'b1;
               cnt          <= '0;
               state        <= ACCESS;
            end
            ACCESS: begin
               if (apbm_pready) begin
                  nat_rdata    <= apbm_pwrite ? '0 : apbm_prdata;
                  nat_err      <= apbm_pslverr;
                  nat_ready    <= 1'b1;
                  apbm_psel    <= 1'b0;
                  apbm_penable <= 1'b0;
                  state        <= DONE;
               end else if (TO_EN && cnt == CNT_MAX) begin
                  nat_rdata    <= '0;
                  nat_err      <= 1'b1;
                  nat_ready    <= 1'b1;
                  apbm_psel    <= 1'b0;
                  apbm_penable <= 1'b0;
                  state        <= DONE;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_native_apb_bridge.sv
// Bench for native_apb_bridge: vector table with an APB slave
// model and a completion scoreboard, plus reset/timeout/b2b cases.
module tb_native_apb_bridge;

   typedef struct {
      logic        write;
      logic [15:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] prdata;
      logic        slverr;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        nt_en = 1'b0;
   logic        nt_rst_n;
   logic        nat_sel = 1'b0;
   logic        nat_write = 1'b0;
   logic [15:0] nat_addr = '0;
   logic [31:0] nat_wdata = '0;
   logic [31:0] nat_rdata;
   logic        nat_ready;
   logic        nat_err;
   logic        apbm_psel;
   logic        apbm_penable;
   logic        apbm_pwrite;
   logic [15:0] apbm_paddr;
   logic [31:0] apbm_pwdata;
   logic [31:0] apbm_prdata = '0;
   logic        apbm_pready = 1'b0;
   logic        apbm_pslverr = 1'b0;

   logic [31:0] nt_rdata;
   logic        nt_ready;
   logic        nt_err;
   logic        nt_psel;
   logic        nt_penable;
   logic        nt_pwrite;
   logic [15:0] nt_paddr;
   logic [31:0] nt_pwdata;

   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sb[$];
   vec_t vt[7];

   assign nt_rst_n = rst_n & nt_en;

   always #5 clk = ~clk;

   native_apb_bridge #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .nat_sel(nat_sel), .nat_write(nat_write),
      .nat_addr(nat_addr), .nat_wdata(nat_wdata),
      .nat_rdata(nat_rdata), .nat_ready(nat_ready), .nat_err(nat_err),
      .apbm_psel(apbm_psel), .apbm_penable(apbm_penable),
      .apbm_pwrite(apbm_pwrite), .apbm_paddr(apbm_paddr),
      .apbm_pwdata(apbm_pwdata), .apbm_prdata(apbm_prdata),
      .apbm_pready(apbm_pready), .apbm_pslverr(apbm_pslverr)
   );

   native_apb_bridge #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(0)) u_nt (
      .clk(clk), .rst_n(nt_rst_n),
      .nat_sel(nat_sel), .nat_write(nat_write),
      .nat_addr(nat_addr), .nat_wdata(nat_wdata),
      .nat_rdata(nt_rdata), .nat_ready(nt_ready), .nat_err(nt_err),
      .apbm_psel(nt_psel), .apbm_penable(nt_penable),
      .apbm_pwrite(nt_pwrite), .apbm_paddr(nt_paddr),
      .apbm_pwdata(nt_pwdata), .apbm_prdata(apbm_prdata),
      .apbm_pready(apbm_pready), .apbm_pslverr(apbm_pslverr)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: event missing", name);
   endtask

   task automatic run_txn(input vec_t v, input bit keep);
      int   acc;
      bit   done;
      exp_t e;
      acc = 0;
      done = 1'b0;
      nat_sel = 1'b1;
      nat_write = v.write;
      nat_addr = v.addr;
      nat_wdata = v.wdata;
      apbm_pready = 1'b0;
      apbm_pslverr = 1'b0;
      sb.push_back('{v.exp_rdata, v.exp_err, v.exp_lat});
      for (int c = 1; c <= 40 && !done; c++) begin
         @(negedge clk);
         apbm_pready = 1'b0;
         apbm_pslverr = 1'b0;
         if (c == 1) begin
            chk("setup_psel", 32'(apbm_psel), 32'd1);
            chk("setup_penable", 32'(apbm_penable), 32'd0);
            chk("setup_paddr", 32'(apbm_paddr), 32'(v.addr));
            chk("setup_pwrite", 32'(apbm_pwrite), 32'(v.write));
            chk("setup_pwdata", apbm_pwdata, v.wdata);
         end
         if (nat_ready) begin
            done = 1'b1;
            if (sb.size() == 0) begin
               fail("sb_empty");
            end else begin
               e = sb.pop_front();
               chk("latency", 32'(c), 32'(e.lat));
               chk("rdata", nat_rdata, e.rdata);
               chk("err", 32'(nat_err), 32'(e.err));
            end
            chk("done_psel", 32'(apbm_psel), 32'd0);
            chk("done_penable", 32'(apbm_penable), 32'd0);
            if (!keep) nat_sel = 1'b0;
         end else if (apbm_psel && apbm_penable) begin
            chk("access_paddr", 32'(apbm_paddr), 32'(v.addr));
            chk("access_pwdata", apbm_pwdata, v.wdata);
            apbm_prdata = v.prdata;
            if (acc == v.waits) begin
               apbm_pready = 1'b1;
               apbm_pslverr = v.slverr;
            end else begin
               apbm_pslverr = 1'b1;
            end
            acc++;
         end
      end
      if (!done) fail("txn_no_ready");
      apbm_pready = 1'b0;
      apbm_pslverr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;

      vt[0] = '{1'b1, 16'h0000, 32'h0000_0041, 0, 32'h0,
                1'b0, 32'h0, 1'b0, 3};
      vt[1] = '{1'b0, 16'h0008, 32'h0, 2, 32'hDEAD_BEEF,
                1'b0, 32'hDEAD_BEEF, 1'b0, 5};
      vt[2] = '{1'b1, 16'h0010, 32'h0000_1111, 0, 32'h7777_7777,
                1'b1, 32'h0, 1'b1, 3};
      vt[3] = '{1'b0, 16'h0004, 32'h0, 1, 32'h1234_5678,
                1'b1, 32'h1234_5678, 1'b1, 4};
      vt[4] = '{1'b0, 16'h0020, 32'h0, 99, 32'hCAFE_F00D,
                1'b0, 32'h0, 1'b1, 7};
      vt[5] = '{1'b1, 16'hFFFC, 32'hA5A5_5A5A, 4, 32'hFFFF_FFFF,
                1'b0, 32'h0, 1'b0, 7};
      vt[6] = '{1'b0, 16'hFFFE, 32'h0, 3, 32'h0BAD_F00D,
                1'b0, 32'h0BAD_F00D, 1'b0, 6};

      repeat (2) @(negedge clk);
      chk("rst_rdata", nat_rdata, 32'h0);
      chk("rst_ready", 32'(nat_ready), 32'd0);
      chk("rst_err", 32'(nat_err), 32'd0);
      chk("rst_psel", 32'(apbm_psel), 32'd0);
      chk("rst_penable", 32'(apbm_penable), 32'd0);
      chk("rst_pwrite", 32'(apbm_pwrite), 32'd0);
      chk("rst_paddr", 32'(apbm_paddr), 32'd0);
      chk("rst_pwdata", apbm_pwdata, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_txn(vt[i], 1'b0);
         @(negedge clk);
      end

      // back-to-back: sel held high through DONE into the next IDLE
      run_txn(vt[0], 1'b1);
      @(negedge clk);
      chk("b2b_gap_psel", 32'(apbm_psel), 32'd0);
      chk("b2b_gap_penable", 32'(apbm_penable), 32'd0);
      run_txn(vt[1], 1'b0);
      @(negedge clk);

      // reset in the middle of ACCESS
      nat_sel = 1'b1;
      nat_write = 1'b1;
      nat_addr = 16'h1234;
      nat_wdata = 32'h0000_55AA;
      repeat (2) @(negedge clk);
      chk("mid_penable", 32'(apbm_penable), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_psel", 32'(apbm_psel), 32'd0);
      chk("mid_rst_penable", 32'(apbm_penable), 32'd0);
      chk("mid_rst_pwrite", 32'(apbm_pwrite), 32'd0);
      chk("mid_rst_paddr", 32'(apbm_paddr), 32'd0);
      chk("mid_rst_pwdata", apbm_pwdata, 32'h0);
      chk("mid_rst_ready", 32'(nat_ready), 32'd0);
      nat_sel = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (nat_ready || apbm_psel) seen = 1'b1;
      end
      chk("mid_rst_quiet", 32'(seen), 32'd0);
      run_txn(vt[6], 1'b0);
      @(negedge clk);

      // TIMEOUT=0 instance never completes a stalled access
      nt_en = 1'b1;
      @(negedge clk);
      nat_sel = 1'b1;
      nat_write = 1'b0;
      nat_addr = 16'h0030;
      apbm_pready = 1'b0;
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (nt_ready) seen = 1'b1;
      end
      chk("nt_no_ready", 32'(seen), 32'd0);
      chk("nt_psel", 32'(nt_psel), 32'd1);
      chk("nt_penable", 32'(nt_penable), 32'd1);
      chk("nt_paddr", 32'(nt_paddr), 32'h0030);
      nat_sel = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      nt_en = 1'b0;
      @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
